// File: rtl/user_merge5to1.sv
// -----------------------------------------------------------------------------
// user_merge5to1
//
// User-side operator for an i5o1 leaf. It takes five 32-bit vld/ack input
// streams from leaf_interface and merges them into one vld/ack output stream
// that goes back toward the BFT.
//
// Each input has its own small FIFO, so that bursts are absorbed. A round-robin
// arbiter picks which FIFO feeds the single output register. The arbiter can
// hold a grant for up to BURST_LEN consecutive words.
//
// Parameters
//   PAYLOAD_BITS    : data width of every stream
//   FIFO_DEPTH_BITS : log2 of the per-input FIFO depth
//   BURST_LEN       : max consecutive words granted to one input (1..15)
//
// Ports
//   clk_user                       in  : user clock, rising edge
//   reset                          in  : synchronous, active-high reset
//   dout_leaf_interface2user_1..5  in  : input stream data
//   vld_interface2user_1..5        in  : input stream valid
//   ack_user2interface_1..5        out : input stream accept. It depends only
//                                        on registered FIFO occupancy and on
//                                        reset.
//   din_leaf_user2interface_1      out : merged output data (registered)
//   vld_user2interface_1           out : merged output valid (registered)
//   ack_interface2user_1           in  : downstream accept
// -----------------------------------------------------------------------------
module user_merge5to1 #(
    parameter int PAYLOAD_BITS    = 32,
    parameter int FIFO_DEPTH_BITS = 1,
    parameter int BURST_LEN       = 1
) (
    input  logic                    clk_user,
    input  logic                    reset,

    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_1,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_2,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_3,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_4,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_5,
    input  logic                    vld_interface2user_1,
    input  logic                    vld_interface2user_2,
    input  logic                    vld_interface2user_3,
    input  logic                    vld_interface2user_4,
    input  logic                    vld_interface2user_5,
    output logic                    ack_user2interface_1,
    output logic                    ack_user2interface_2,
    output logic                    ack_user2interface_3,
    output logic                    ack_user2interface_4,
    output logic                    ack_user2interface_5,

    output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_1,
    output logic                    vld_user2interface_1,
    input  logic                    ack_interface2user_1
);

    localparam int              NUM_IN      = 5;
    localparam int              DEPTH       = 2 ** FIFO_DEPTH_BITS;
    localparam int              CNT_W       = FIFO_DEPTH_BITS + 1;
    localparam logic [2:0]      LAST_INPUT  = 3'd4;
    localparam logic [3:0]      BURST_LEN_C = 4'(BURST_LEN);

    // ------------------------------------------------------------------
    // Round-robin search. Offsets from base+1 up to base+5 are tried. Offset
    // 5 is base itself, so it has the lowest priority. The offsets are
    // scanned from the far end down, so the nearest non-empty input is the
    // last one written and therefore wins.
    // Return value is {found, index}.
    // ------------------------------------------------------------------
    function automatic logic [3:0] rr_search(input logic [2:0] base,
                                             input logic [7:0] nonempty);
        logic [3:0] result;
        logic [3:0] sum;
        logic [2:0] cand;
        result = 4'b0000;
        for (int off = NUM_IN; off >= 1; off--) begin
            sum    = {1'b0, base} + 4'(off);
            cand   = (sum >= 4'(NUM_IN)) ? 3'(sum - 4'(NUM_IN)) : sum[2:0];
            result = nonempty[cand] ? {1'b1, cand} : result;
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Input bundling
    // ------------------------------------------------------------------
    logic [PAYLOAD_BITS-1:0] in_data_s [NUM_IN];
    logic [NUM_IN-1:0]       in_vld_s;
    logic [NUM_IN-1:0]       in_ack_s;
    logic [NUM_IN-1:0]       push_s;
    logic [NUM_IN-1:0]       pop_s;
    logic [7:0]              nonempty_s;
    logic [PAYLOAD_BITS-1:0] head_s [NUM_IN];

    assign in_data_s[0] = dout_leaf_interface2user_1;
    assign in_data_s[1] = dout_leaf_interface2user_2;
    assign in_data_s[2] = dout_leaf_interface2user_3;
    assign in_data_s[3] = dout_leaf_interface2user_4;
    assign in_data_s[4] = dout_leaf_interface2user_5;
    assign in_vld_s     = {vld_interface2user_5, vld_interface2user_4,
                           vld_interface2user_3, vld_interface2user_2,
                           vld_interface2user_1};

    assign ack_user2interface_1 = in_ack_s[0];
    assign ack_user2interface_2 = in_ack_s[1];
    assign ack_user2interface_3 = in_ack_s[2];
    assign ack_user2interface_4 = in_ack_s[3];
    assign ack_user2interface_5 = in_ack_s[4];

    // The vector is widened to 8 entries so that any 3-bit grant index
    // selects a defined bit.
    assign nonempty_s[7:NUM_IN] = '0;

    // ------------------------------------------------------------------
    // Per-input FIFOs
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_IN; k++) begin : g_fifo
        logic [PAYLOAD_BITS-1:0]    mem_r [DEPTH];
        logic [FIFO_DEPTH_BITS-1:0] wr_ptr_r;
        logic [FIFO_DEPTH_BITS-1:0] rd_ptr_r;
        logic [CNT_W-1:0]           count_r;

        // Ready comes only from the registered count, so there is no
        // combinational path from vld to ack. A FIFO that has just filled
        // drops ack on the following cycle.
        assign in_ack_s[k]   = ~reset & (count_r < CNT_W'(DEPTH));
        assign push_s[k]     = in_vld_s[k] & in_ack_s[k];
        assign nonempty_s[k] = (count_r != '0);
        assign head_s[k]     = mem_r[rd_ptr_r];

        // FIFO storage, pointers and occupancy. Push and pop in the same
        // cycle leave the count unchanged.
        always_ff @(posedge clk_user) begin
            if (reset) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
            end else begin
                if (push_s[k]) begin
                    mem_r[wr_ptr_r] <= in_data_s[k];
                    wr_ptr_r        <= wr_ptr_r + FIFO_DEPTH_BITS'(1);
                end
                if (pop_s[k]) begin
                    rd_ptr_r <= rd_ptr_r + FIFO_DEPTH_BITS'(1);
                end
                case ({push_s[k], pop_s[k]})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter and output register state
    // ------------------------------------------------------------------
    logic [2:0]              gnt_r;
    logic [3:0]              burst_cnt_r;
    logic                    out_vld_r;
    logic [PAYLOAD_BITS-1:0] out_data_r;

    logic                    slot_free_s;
    logic [3:0]              search_s;
    logic                    hold_s;
    logic                    win_found_s;
    logic [2:0]              win_idx_s;
    logic [PAYLOAD_BITS-1:0] win_data_s;

    logic [2:0]              gnt_next_s;
    logic [3:0]              burst_next_s;
    logic                    out_vld_next_s;
    logic [PAYLOAD_BITS-1:0] out_data_next_s;

    assign slot_free_s = ~out_vld_r | ack_interface2user_1;

    // Winner selection. A burst_cnt of zero means that no burst owner exists
    // yet, which is the state right after reset. In that case the hold path
    // is skipped, and the search from gnt=5 makes input 1 the first
    // candidate.
    always_comb begin
        search_s = rr_search(gnt_r, nonempty_s);
        if ((burst_cnt_r != 4'd0) && (burst_cnt_r < BURST_LEN_C) && nonempty_s[gnt_r]) begin
            hold_s      = 1'b1;
            win_found_s = 1'b1;
            win_idx_s   = gnt_r;
        end else begin
            hold_s      = 1'b0;
            win_found_s = search_s[3];
            win_idx_s   = search_s[2:0];
        end
    end

    // Select the head word of the winning FIFO.
    always_comb begin
        win_data_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            win_data_s = win_data_s | (head_s[k] & {PAYLOAD_BITS{win_idx_s == 3'(k)}});
        end
    end

    // Next state of the grant, the burst counter and the output register.
    // Nothing is popped unless the output slot is free.
    always_comb begin
        gnt_next_s      = gnt_r;
        burst_next_s    = burst_cnt_r;
        out_vld_next_s  = out_vld_r;
        out_data_next_s = out_data_r;
        pop_s           = '0;
        if (slot_free_s) begin
            if (win_found_s) begin
                pop_s           = NUM_IN'(1) << win_idx_s;
                out_vld_next_s  = 1'b1;
                out_data_next_s = win_data_s;
                gnt_next_s      = win_idx_s;
                burst_next_s    = hold_s ? (burst_cnt_r + 4'd1) : 4'd1;
            end else begin
                out_vld_next_s  = 1'b0;
            end
        end else begin
            pop_s = '0;
        end
    end

    // State register for the arbiter and the output stage.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            gnt_r       <= LAST_INPUT;
            burst_cnt_r <= 4'd0;
            out_vld_r   <= 1'b0;
            out_data_r  <= '0;
        end else begin
            gnt_r       <= gnt_next_s;
            burst_cnt_r <= burst_next_s;
            out_vld_r   <= out_vld_next_s;
            out_data_r  <= out_data_next_s;
        end
    end

    assign din_leaf_user2interface_1 = out_data_r;
    assign vld_user2interface_1      = out_vld_r;

endmodule

// File: tb/tb_user_merge5to1.sv
// -----------------------------------------------------------------------------
// tb_user_merge5to1
//
// Two instances are driven side by side: one with BURST_LEN=1 (d0) and one
// with BURST_LEN=4 (d1). Each instance has its own five producers.
//
// A queue-based reference model predicts every output on every cycle: the
// five acks, the output valid and the output data. Expected acks come from
// the model's queue sizes, so producers fire on model values and never on
// values read back from the DUT.
// -----------------------------------------------------------------------------
module tb_user_merge5to1;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic clk_user = 1'b0;
    always #5 clk_user = ~clk_user;

    logic         reset;
    logic         down_ack;
    logic [W-1:0] data_s     [10];
    logic         vld_s      [10];
    logic         ack_s      [10];
    logic [W-1:0] out_data_s [2];
    logic         out_vld_s  [2];

    user_merge5to1 #(.PAYLOAD_BITS(32), .FIFO_DEPTH_BITS(1), .BURST_LEN(1)) dut_rr (
        .clk_user                   (clk_user),
        .reset                      (reset),
        .dout_leaf_interface2user_1 (data_s[0]),
        .dout_leaf_interface2user_2 (data_s[1]),
        .dout_leaf_interface2user_3 (data_s[2]),
        .dout_leaf_interface2user_4 (data_s[3]),
        .dout_leaf_interface2user_5 (data_s[4]),
        .vld_interface2user_1       (vld_s[0]),
        .vld_interface2user_2       (vld_s[1]),
        .vld_interface2user_3       (vld_s[2]),
        .vld_interface2user_4       (vld_s[3]),
        .vld_interface2user_5       (vld_s[4]),
        .ack_user2interface_1       (ack_s[0]),
        .ack_user2interface_2       (ack_s[1]),
        .ack_user2interface_3       (ack_s[2]),
        .ack_user2interface_4       (ack_s[3]),
        .ack_user2interface_5       (ack_s[4]),
        .din_leaf_user2interface_1  (out_data_s[0]),
        .vld_user2interface_1       (out_vld_s[0]),
        .ack_interface2user_1       (down_ack)
    );

    user_merge5to1 #(.PAYLOAD_BITS(32), .FIFO_DEPTH_BITS(1), .BURST_LEN(4)) dut_burst (
        .clk_user                   (clk_user),
        .reset                      (reset),
        .dout_leaf_interface2user_1 (data_s[5]),
        .dout_leaf_interface2user_2 (data_s[6]),
        .dout_leaf_interface2user_3 (data_s[7]),
        .dout_leaf_interface2user_4 (data_s[8]),
        .dout_leaf_interface2user_5 (data_s[9]),
        .vld_interface2user_1       (vld_s[5]),
        .vld_interface2user_2       (vld_s[6]),
        .vld_interface2user_3       (vld_s[7]),
        .vld_interface2user_4       (vld_s[8]),
        .vld_interface2user_5       (vld_s[9]),
        .ack_user2interface_1       (ack_s[5]),
        .ack_user2interface_2       (ack_s[6]),
        .ack_user2interface_3       (ack_s[7]),
        .ack_user2interface_4       (ack_s[8]),
        .ack_user2interface_5       (ack_s[9]),
        .din_leaf_user2interface_1  (out_data_s[1]),
        .vld_user2interface_1       (out_vld_s[1]),
        .ack_interface2user_1       (down_ack)
    );

    // Producer state. left = words still to send, seq = next data word,
    // held = the word offered last cycle was not accepted.
    int         left [10];
    logic [W-1:0] seq [10];
    bit         held [10];
    int         vld_prob;
    int         down_prob;
    bit         chk_en;

    // Reference model. Index = instance*5 + input.
    logic [W-1:0] q [10][$];
    int           m_gnt    [2];
    bit           m_active [2];
    int           m_bcnt   [2];
    bit           m_vld    [2];
    logic [W-1:0] m_data   [2];
    int           m_take   [2];
    int           dut_take [2];
    int           burst_len [2];

    int n_checks;
    int n_pass;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model of one instance across one rising edge.
    task automatic model_edge(input int d, input bit fire [10]);
        int win;
        int c;
        if (reset) begin
            for (int k = 0; k < 5; k++) q[d*5+k].delete();
            m_vld[d]    = 1'b0;
            m_data[d]   = 32'h0;
            m_gnt[d]    = 4;
            m_active[d] = 1'b0;
            m_bcnt[d]   = 0;
        end else begin
            if (!m_vld[d] || down_ack) begin
                win = -1;
                if (m_active[d] && m_bcnt[d] < burst_len[d] && q[d*5+m_gnt[d]].size() > 0) begin
                    win = m_gnt[d];
                    m_bcnt[d]++;
                end else begin
                    for (int j = 1; j <= 5; j++) begin
                        c = (m_gnt[d] + j) % 5;
                        if (win < 0 && q[d*5+c].size() > 0) win = c;
                    end
                    if (win >= 0) begin
                        m_gnt[d]    = win;
                        m_bcnt[d]   = 1;
                        m_active[d] = 1'b1;
                    end
                end
                if (win >= 0) begin
                    m_data[d] = q[d*5+win].pop_front();
                    m_vld[d]  = 1'b1;
                end else begin
                    m_vld[d]  = 1'b0;
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (fire[d*5+k]) q[d*5+k].push_back(data_s[d*5+k]);
            end
        end
    endtask

    // One clock cycle: drive the inputs, check at the falling edge, then
    // advance the model at the rising edge.
    task automatic run_cycle();
        bit fire [10];
        bit exp_ack;
        for (int i = 0; i < 10; i++) begin
            if (!held[i]) vld_s[i] = (left[i] > 0) && (int'($urandom_range(99)) < vld_prob);
            data_s[i] = seq[i];
        end
        down_ack = (int'($urandom_range(99)) < down_prob);
        @(negedge clk_user);
        for (int i = 0; i < 10; i++) begin
            exp_ack = !reset && (q[i].size() < DEPTH);
            if (chk_en) check_val($sformatf("ack d%0d in%0d", i/5, i%5+1), 32'(ack_s[i]), 32'(exp_ack));
            fire[i] = vld_s[i] && exp_ack;
        end
        for (int d = 0; d < 2; d++) begin
            if (chk_en) begin
                check_val($sformatf("out_vld d%0d", d), 32'(out_vld_s[d]), 32'(m_vld[d]));
                check_val($sformatf("out_data d%0d", d), out_data_s[d], m_data[d]);
            end
            if (m_vld[d] && down_ack) m_take[d]++;
            if (out_vld_s[d] && down_ack) dut_take[d]++;
        end
        @(posedge clk_user);
        for (int d = 0; d < 2; d++) model_edge(d, fire);
        for (int i = 0; i < 10; i++) begin
            if (fire[i]) begin
                seq[i] = seq[i] + 32'd1;
                if (left[i] > 0) left[i]--;
            end
            held[i] = vld_s[i] && !fire[i];
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        burst_len[0] = 1;
        burst_len[1] = 4;
        for (int d = 0; d < 2; d++) begin
            m_gnt[d] = 4; m_active[d] = 1'b0; m_bcnt[d] = 0;
            m_vld[d] = 1'b0; m_data[d] = 32'h0; m_take[d] = 0; dut_take[d] = 0;
        end
        for (int i = 0; i < 10; i++) begin
            vld_s[i] = 1'b0; data_s[i] = 32'h0; held[i] = 1'b0;
            left[i] = 1; seq[i] = 32'hA000 + 32'(i);
        end

        // Reset held for 3 cycles with every input valid.
        vld_prob = 100; down_prob = 100; reset = 1'b1; chk_en = 1'b0;
        run(1);
        chk_en = 1'b1;
        run(2);
        reset = 1'b0;
        run(8);

        // A single stream on input 3: 0x1..0x10.
        for (int d = 0; d < 2; d++) begin
            seq[d*5+2] = 32'h1; left[d*5+2] = 16;
        end
        run(30);

        // All five inputs saturated, input k sends 0xk000+n.
        for (int i = 0; i < 10; i++) begin
            seq[i] = 32'h1000 * 32'(i % 5 + 1); left[i] = 1000;
        end
        run(40);

        // Only inputs 1 and 2 are active, then input 1 runs dry after 2 words.
        for (int d = 0; d < 2; d++) for (int k = 2; k < 5; k++) left[d*5+k] = 0;
        run(30);
        for (int d = 0; d < 2; d++) left[d*5] = 2;
        run(20);
        for (int i = 0; i < 10; i++) left[i] = 0;
        run(12);

        // Downstream backpressure for 10 cycles with all inputs active.
        for (int i = 0; i < 10; i++) left[i] = 1000;
        run(3);
        down_prob = 0;
        run(10);
        down_prob = 100;
        run(20);

        // A one-cycle reset pulse in the middle of saturated traffic.
        run(5);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(15);

        // Random valid and downstream-ack patterns.
        for (int i = 0; i < 10; i++) begin
            seq[i] = $urandom; left[i] = 1000;
        end
        vld_prob = 60; down_prob = 70;
        run(400);

        // Drain everything.
        for (int i = 0; i < 10; i++) left[i] = 0;
        vld_prob = 100; down_prob = 100;
        run(20);

        check_val("d0 words delivered", 32'(dut_take[0]), 32'(m_take[0]));
        check_val("d1 words delivered", 32'(dut_take[1]), 32'(m_take[1]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
